// File: rtl/input_part_if.sv
// Handshake/data bundle between the serial number source, input_part and the sorter.
interface input_part_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             clear;
    logic             sort_done;
    logic             ready;
    logic [WIDTH-1:0] num0;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [WIDTH-1:0] num3;
    logic             start_sort;
    logic [2:0]       fill_count;
    logic             drop_err;

    modport master (
        output data_in, data_valid, clear, sort_done,
        input  ready, num0, num1, num2, num3, start_sort, fill_count, drop_err
    );

    modport slave (
        input  data_in, data_valid, clear, sort_done,
        output ready, num0, num1, num2, num3, start_sort, fill_count, drop_err
    );
endinterface

// File: rtl/input_part.sv
// Collects four serial numbers into parallel slots, pulses start_sort once,
// then holds the set until the sorter reports sort_done.
module input_part #(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    input_part_if.slave bus
);

    typedef enum logic [1:0] {StCollect, StLaunch, StBusy} state_e;

    state_e           state_q;
    logic [1:0]       idx_q;
    logic [WIDTH-1:0] num_q [4];
    logic [2:0]       fill_q;
    logic             ready_q;
    logic             start_q;
    logic             drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StCollect;
            idx_q   <= 2'd0;
            fill_q  <= 3'd0;
            ready_q <= 1'b1;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < 4; i++) num_q[i] <= '0;
        end else if (bus.clear) begin
            // Abort the set; slot contents are deliberately left as they are.
            state_q <= StCollect;
            idx_q   <= 2'd0;
            fill_q  <= 3'd0;
            ready_q <= 1'b1;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (bus.data_valid) begin
                        num_q[idx_q] <= bus.data_in;
                        fill_q       <= fill_q + 3'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= StLaunch;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                StLaunch: begin
                    // sort_done is not looked at here: the pulse always completes.
                    state_q <= StBusy;
                    start_q <= 1'b0;
                    if (bus.data_valid) drop_q <= 1'b1;
                end
                StBusy: begin
                    if (bus.data_valid) drop_q <= 1'b1;
                    if (bus.sort_done) begin
                        state_q <= StCollect;
                        idx_q   <= 2'd0;
                        fill_q  <= 3'd0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StCollect;
                    idx_q   <= 2'd0;
                    fill_q  <= 3'd0;
                    ready_q <= 1'b1;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.start_sort = start_q;
    assign bus.fill_count = fill_q;
    assign bus.drop_err   = drop_q;
    assign bus.num0       = num_q[0];
    assign bus.num1       = num_q[1];
    assign bus.num2       = num_q[2];
    assign bus.num3       = num_q[3];

endmodule
